ahb_lite_mem_slave: RTL and testbench
=====================================

AHB_LITE_MEM_SLAVE -- requirements
Module: ahb_lite_mem_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning number of 32-bit words of storage (power of two, 16..65536).
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning the number of HREADYOUT=0 cycles inserted in every valid transfer's data phase (0..7).
REQ-003 SHALL be clocked by HCLK, one clock; reset is asynchronous and active-low on HRESETn.
REQ-004 SHALL have ports, listed as name, direction, width, meaning:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  000 byte, 001 halfword, 010 word.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready; previous transfer complete.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

Function
REQ-005 SHALL capture an address phase on a rising HCLK edge when HSEL=1, HREADY=1 and HTRANS[1]=1, registering HADDR, HWRITE, HSIZE and an "error" flag.
REQ-006 SHALL treat IDLE, BUSY or HSEL=0 address phases as no-access, completing with a zero-wait OKAY (HREADYOUT=1, HRESP=0).
REQ-007 SHALL implement data-phase states IDLE, WAIT, DONE, ERR1 and ERR2, and a 3-bit wait counter.
REQ-008 SHALL, for a captured valid transfer, drive HREADYOUT=0 for exactly WAIT_STATES cycles (state WAIT), then HREADYOUT=1 for one cycle (DONE); WAIT_STATES=0 SHALL go directly to DONE.
REQ-009 SHALL, in DONE for a read, drive HRDATA with the full 32-bit word at HADDR[..:2] regardless of HSIZE; all other cycles HRDATA=0.
REQ-010 SHALL, in DONE for a write, commit HWDATA byte lanes selected by the captured HSIZE/HADDR[1:0]: byte writes lane HADDR[1:0], halfword writes lanes {HADDR[1],0} and +1, and word writes all four lanes.
REQ-011 SHALL accept a new address phase in the same cycle as DONE (HREADY=1), giving back-to-back pipelined transfers with no idle cycle.
REQ-012 SHALL make a write in DONE visible to a read whose data phase immediately follows.
REQ-013 SHALL NOT sample address phases while HREADY=0; HADDR and HTRANS changes during wait states SHALL be ignored.
REQ-014 SHALL flag a transfer as an error if HSIZE>010, if it is a misaligned halfword (HADDR[0]=1), or if it is a misaligned word (HADDR[1:0]!=00).
REQ-015 SHALL respond to an error transfer with a two-cycle ERROR: ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1), with no memory write.
REQ-016 SHALL ignore an address phase presented during ERR2; it SHALL NOT be captured.
REQ-017 SHALL return from DONE or ERR2 to IDLE when no new transfer is captured.

Reset
REQ-018 SHALL, while HRESETn=0, force state IDLE, wait counter 0, HREADYOUT=1, HRESP=0 and HRDATA=0.
REQ-019 SHALL discard an in-flight transfer when reset asserts mid-data-phase; a pending write SHALL NOT commit.
REQ-020 SHALL NOT reset memory contents.

Configuration
REQ-021 SHALL, with macro AHB_MEM_RANGE_CHECK_EN defined, also flag as an error any transfer with HADDR[31:2] >= MEM_WORDS, answering it per REQ-015.
REQ-022 SHALL, without AHB_MEM_RANGE_CHECK_EN, index memory with HADDR[log2(MEM_WORDS)+1:2] only, so out-of-range addresses alias modulo size.

Verification
REQ-023 SHALL pass: with WAIT_STATES=1, word write 0xDEADBEEF to 0x10, then a read of 0x10 -> write data phase of 2 cycles, read returns 0xDEADBEEF with HRESP=0.
REQ-024 SHALL pass: word 0x11223344 at 0x20, then byte write 0xAA on lane 1 at 0x21 and a read of 0x20 -> read returns 0x1122AA44.
REQ-025 SHALL pass: with WAIT_STATES=0, a 4-beat NONSEQ/SEQ read burst at 0x40 -> 4 consecutive HREADYOUT=1 cycles carrying words 0x40..0x4C.
REQ-026 SHALL pass: word read at 0x02 -> HREADYOUT 0 then 1 with HRESP=1 on both cycles, and no state change.
REQ-027 SHALL pass: with AHB_MEM_RANGE_CHECK_EN and MEM_WORDS=1024, a read of 0x1000 -> ERROR; without the macro, the same read returns the word at 0x0.
REQ-028 SHALL pass: HRESETn pulsed low during the WAIT cycle of a write of 0x55 to 0x8 -> outputs return to reset values, and a later read of 0x8 returns the old value.

Source files
------------

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite word-organised memory slave with fixed wait states and two-cycle ERROR response.
// Optional address range check: define AHB_MEM_RANGE_CHECK_EN.
module ahb_lite_mem_slave #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);
  localparam int         AW      = $clog2(MEM_WORDS);
  localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

  state_t        st;
  logic [2:0]    wcnt;
  logic [AW+1:0] a_addr;
  logic          a_write;
  logic [2:0]    a_size;
  logic [31:0]   mem [MEM_WORDS];

  logic          cap, fmt_err, req_err, commit;
  logic [AW-1:0] a_idx, rd_idx;
  logic [3:0]    be;
  logic [31:0]   rd_word;
  logic          unused_ok;

  // Address phases are only taken where this slave itself is ready; ERR2 drops them.
  assign cap     = (st == S_IDLE || st == S_DONE) && HSEL && HREADY && HTRANS[1];
  assign fmt_err = (HSIZE > 3'b010) || (HSIZE == 3'b001 && HADDR[0]) ||
                   (HSIZE == 3'b010 && HADDR[1:0] != 2'b00);
`ifdef AHB_MEM_RANGE_CHECK_EN
  assign req_err = fmt_err || (|HADDR[31:AW+2]);
`else
  assign req_err = fmt_err;
`endif
  assign unused_ok = &{1'b0, HTRANS[0], HADDR[31:AW+2]};

  assign a_idx  = a_addr[AW+1:2];
  assign commit = (st == S_DONE) && a_write;
  assign rd_idx = (WAIT_STATES == 0 && cap) ? HADDR[AW+1:2] : a_idx;

  // Read word bypasses a write committing on the same edge (zero-wait back-to-back).
  always_comb begin
    case (a_size)
      3'b000:  be = 4'b0001 << a_addr[1:0];
      3'b001:  be = a_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    rd_word = mem[rd_idx];
    for (int b = 0; b < 4; b++)
      if (commit && be[b] && a_idx == rd_idx) rd_word[8*b +: 8] = HWDATA[8*b +: 8];
  end

  always_ff @(posedge HCLK)
    if (commit)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[a_idx][8*b +: 8] <= HWDATA[8*b +: 8];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      st        <= S_IDLE;
      wcnt      <= 3'd0;
      a_addr    <= '0;
      a_write   <= 1'b0;
      a_size    <= 3'd0;
      HRDATA    <= 32'h0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
    end else begin
      HRDATA    <= 32'h0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      case (st)
        S_WAIT: begin
          if (wcnt == 3'd0) begin
            st <= S_DONE;
            if (!a_write) HRDATA <= rd_word;
          end else begin
            wcnt      <= wcnt - 3'd1;
            HREADYOUT <= 1'b0;
          end
        end
        S_ERR1: begin
          st    <= S_ERR2;
          HRESP <= 1'b1;
        end
        S_ERR2: st <= S_IDLE;
        default: begin
          if (cap) begin
            a_addr  <= HADDR[AW+1:0];
            a_write <= HWRITE;
            a_size  <= HSIZE;
            if (req_err) begin
              st        <= S_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              st <= S_DONE;
              if (!HWRITE) HRDATA <= rd_word;
            end else begin
              st        <= S_WAIT;
              wcnt      <= WS_LOAD;
              HREADYOUT <= 1'b0;
            end
          end else begin
            st <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Bench for ahb_lite_mem_slave: one instance with one wait state (index 0), one with none (index 1).
module tb_ahb_lite_mem_slave;
  localparam int MW = 1024;

  logic HCLK = 1'b0, HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  logic [1:0]       hsel, hwrite, hreadyout, hresp, hready;
  logic [1:0][1:0]  htrans;
  logic [1:0][2:0]  hsize;
  logic [1:0][31:0] haddr, hwdata, hrdata;
  assign hready = hreadyout;

  ahb_lite_mem_slave #(.MEM_WORDS(MW), .WAIT_STATES(1)) u_ws1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]), .HREADY(hready[0]),
    .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]));
  ahb_lite_mem_slave #(.MEM_WORDS(MW), .WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]), .HREADY(hready[1]),
    .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]));

  typedef struct { bit sel; logic [1:0] trans; bit wr; logic [2:0] size; logic [31:0] addr, wdata; } xf_t;
  // got/exp packing: {wait cycles[4], resp in last wait, resp at end, OR of rdata in waits, rdata at end}
  typedef struct { logic [69:0] got, exp; } res_t;

  xf_t         q[$];
  res_t        rs[$];
  logic [31:0] mdl [2][MW];
  int          checks = 0, errors = 0;

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic xf_t mk(input bit wr, input int size, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [1:0] tr = 2'b10);
    xf_t x;
    x.sel = 1'b1; x.trans = tr; x.wr = wr; x.size = 3'(size); x.addr = addr; x.wdata = wd;
    return x;
  endfunction

  function automatic bit is_err(input xf_t x);
    bit e;
    e = (x.size > 3'd2) || ((x.addr % (32'd1 << x.size)) != 0);
`ifdef AHB_MEM_RANGE_CHECK_EN
    e = e || ((x.addr >> 2) >= MW);
`endif
    return e;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % MW);
  endfunction

  task automatic model_write(input int d, input xf_t x);
    int nb, base, lane;
    nb   = 1 << x.size;
    base = (int'(x.addr % 4) / nb) * nb;
    for (int k = 0; k < nb; k++) begin
      lane = base + k;
      mdl[d][widx(x.addr)][8*lane +: 8] = x.wdata[8*lane +: 8];
    end
  endtask

  // Drives queue q as a pipelined master on bus d and records one result per data phase or idle cycle.
  task automatic run_seq(input int d);
    xf_t cur;
    res_t r;
    bit act, cur_err, drop, rdy, rsp, rspw;
    int idx, cyc, waits;
    logic [31:0] rd, rdw, er;
    act = 0; cur_err = 0; drop = 0; rspw = 0; idx = 0; cyc = 0; waits = 0; rdw = 0;
    cur = mk(0, 0, 0, 0, 2'b00);
    rs.delete();
    while ((idx < q.size() || act) && cyc < 500) begin
      cyc++;
      if (idx < q.size()) begin
        hsel[d] = q[idx].sel; htrans[d] = q[idx].trans; hwrite[d] = q[idx].wr;
        hsize[d] = q[idx].size; haddr[d] = q[idx].addr;
      end else begin
        hsel[d] = 1'b0; htrans[d] = 2'b00;
      end
      hwdata[d] = act ? cur.wdata : 32'h0;
      @(negedge HCLK);
      rdy = hreadyout[d]; rsp = hresp[d]; rd = hrdata[d];
      if (act && !rdy) begin
        waits++; rspw = rsp; rdw |= rd;
      end else if (act) begin
        er = (cur_err || cur.wr) ? 32'h0 : mdl[d][widx(cur.addr)];
        r.got = {4'(waits), rspw, rsp, rdw, rd};
        r.exp = {cur_err ? 4'd1 : 4'(ws_of(d)), cur_err, cur_err, 32'h0, er};
        rs.push_back(r);
        if (!cur_err && cur.wr) model_write(d, cur);
        drop = cur_err;
      end else begin
        r.got = {4'(!rdy), 1'b0, rsp, 32'h0, rd};
        r.exp = '0;
        rs.push_back(r);
      end
      @(posedge HCLK); #1;
      if (rdy) begin
        act = 0;
        if (idx < q.size()) begin
          cur = q[idx]; idx++;
          act = !drop && cur.sel && cur.trans[1];
          cur_err = is_err(cur);
          waits = 0; rspw = 0; rdw = 0;
        end
        drop = 0;
      end
    end
    hsel[d] = 1'b0; htrans[d] = 2'b00; hwdata[d] = 32'h0;
    if (act || idx < q.size()) begin
      r.got = '1; r.exp = '0;
      rs.push_back(r);
    end
    q.delete();
  endtask

  task automatic test_reset();
    #12;
    for (int d = 0; d < 2; d++) begin
      checks++; if (hreadyout[d] !== 1'b1) begin errors++; $display("FAIL reset_hreadyout[%0d] got %b exp 1", d, hreadyout[d]); end
      checks++; if (hresp[d] !== 1'b0) begin errors++; $display("FAIL reset_hresp[%0d] got %b exp 0", d, hresp[d]); end
      checks++; if (hrdata[d] !== 32'h0) begin errors++; $display("FAIL reset_hrdata[%0d] got %h exp 0", d, hrdata[d]); end
    end
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;
  endtask

  task automatic test_basic();
    q.push_back(mk(1, 2, 32'h10, 32'hDEADBEEF));
    q.push_back(mk(0, 2, 32'h10, 32'h0));
    run_seq(0);
    foreach (rs[i]) begin checks++; if (rs[i].got !== rs[i].exp) begin errors++; $display("FAIL basic[%0d] got %h exp %h", i, rs[i].got, rs[i].exp); end end
    checks++; if (rs[rs.size()-1].got[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rdata got %h exp deadbeef", rs[rs.size()-1].got[31:0]); end
  endtask

  task automatic test_byte_lanes();
    q.push_back(mk(1, 2, 32'h20, 32'h11223344));
    q.push_back(mk(1, 0, 32'h21, 32'h0000AA00));
    q.push_back(mk(0, 2, 32'h20, 32'h0));
    run_seq(0);
    foreach (rs[i]) begin checks++; if (rs[i].got !== rs[i].exp) begin errors++; $display("FAIL byte_lanes[%0d] got %h exp %h", i, rs[i].got, rs[i].exp); end end
    checks++; if (rs[rs.size()-1].got[31:0] !== 32'h1122AA44) begin errors++; $display("FAIL byte_lane_rdata got %h exp 1122aa44", rs[rs.size()-1].got[31:0]); end
  endtask

  task automatic test_burst();
    int n;
    for (int k = 0; k < 4; k++) q.push_back(mk(1, 2, 32'h40 + 4*k, 32'hB0000040 + 4*k));
    for (int k = 0; k < 4; k++) q.push_back(mk(0, 2, 32'h40 + 4*k, 32'h0, (k == 0) ? 2'b10 : 2'b11));
    run_seq(1);
    foreach (rs[i]) begin checks++; if (rs[i].got !== rs[i].exp) begin errors++; $display("FAIL burst[%0d] got %h exp %h", i, rs[i].got, rs[i].exp); end end
    n = rs.size();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rs[n-4+k].got[31:0] !== 32'hB0000040 + 4*k || rs[n-4+k].got[69:66] !== 4'd0) begin
        errors++; $display("FAIL burst_beat[%0d] got %h exp %h", k, rs[n-4+k].got[31:0], 32'hB0000040 + 4*k);
      end
    end
  endtask

  task automatic test_back_to_back();
    q.push_back(mk(1, 2, 32'h80, 32'h11111111));
    q.push_back(mk(1, 0, 32'h81, 32'h00002200));
    q.push_back(mk(0, 2, 32'h80, 32'h0));
    q.push_back(mk(1, 1, 32'h82, 32'h55660000));
    q.push_back(mk(0, 2, 32'h80, 32'h0));
    run_seq(1);
    foreach (rs[i]) begin checks++; if (rs[i].got !== rs[i].exp) begin errors++; $display("FAIL back_to_back[%0d] got %h exp %h", i, rs[i].got, rs[i].exp); end end
    checks++; if (rs[rs.size()-1].got[31:0] !== 32'h55662211) begin errors++; $display("FAIL b2b_rdata got %h exp 55662211", rs[rs.size()-1].got[31:0]); end
  endtask

  task automatic test_error();
    q.push_back(mk(1, 2, 32'h10, 32'h01234567));
    q.push_back(mk(0, 2, 32'h02, 32'h0));
    q.push_back(mk(1, 2, 32'h10, 32'h0BAD0BAD));  // presented during ERR2: must be dropped
    q.push_back(mk(0, 2, 32'h10, 32'h0));
    run_seq(0);
    foreach (rs[i]) begin checks++; if (rs[i].got !== rs[i].exp) begin errors++; $display("FAIL error[%0d] got %h exp %h", i, rs[i].got, rs[i].exp); end end
    checks++; if (rs[2].got[69:64] !== 6'b000111) begin errors++; $display("FAIL error_resp got %b exp 000111", rs[2].got[69:64]); end
    checks++; if (rs[rs.size()-1].got[31:0] !== 32'h01234567) begin errors++; $display("FAIL err2_ignored got %h exp 01234567", rs[rs.size()-1].got[31:0]); end
    q.push_back(mk(0, 1, 32'h11, 32'h0));
    q.push_back(mk(0, 0, 32'h0, 32'h0, 2'b00));
    q.push_back(mk(1, 3, 32'h10, 32'hFFFFFFFF));
    q.push_back(mk(0, 0, 32'h0, 32'h0, 2'b01));
    q.push_back(mk(0, 2, 32'h10, 32'h0));
    for (int d = 0; d < 2; d++) begin
      if (d == 1) begin
        q.push_back(mk(1, 2, 32'h10, 32'h76543210));
        q.push_back(mk(1, 1, 32'h13, 32'hFFFFFFFF));
        q.push_back(mk(0, 0, 32'h0, 32'h0, 2'b00));
        q.push_back(mk(0, 2, 32'h10, 32'h0));
      end
      run_seq(d);
      foreach (rs[i]) begin checks++; if (rs[i].got !== rs[i].exp) begin errors++; $display("FAIL error_b%0d[%0d] got %h exp %h", d, i, rs[i].got, rs[i].exp); end end
    end
    checks++; if (rs[rs.size()-1].got[31:0] !== 32'h76543210) begin errors++; $display("FAIL err_nowrite got %h exp 76543210", rs[rs.size()-1].got[31:0]); end
  endtask

  task automatic test_range();
    q.push_back(mk(1, 2, 32'h0, 32'hA5A50000));
    q.push_back(mk(0, 2, 32'h1000, 32'h0));
    run_seq(0);
    foreach (rs[i]) begin checks++; if (rs[i].got !== rs[i].exp) begin errors++; $display("FAIL range[%0d] got %h exp %h", i, rs[i].got, rs[i].exp); end end
`ifdef AHB_MEM_RANGE_CHECK_EN
    checks++; if (rs[rs.size()-1].got[68:67] !== 2'b11) begin errors++; $display("FAIL range_err got %b exp 11", rs[rs.size()-1].got[68:67]); end
`else
    checks++; if (rs[rs.size()-1].got[31:0] !== 32'hA5A50000) begin errors++; $display("FAIL range_alias got %h exp a5a50000", rs[rs.size()-1].got[31:0]); end
`endif
  endtask

  task automatic test_reset_mid();
    q.push_back(mk(1, 2, 32'h8, 32'hCAFE0008));
    run_seq(0);
    foreach (rs[i]) begin checks++; if (rs[i].got !== rs[i].exp) begin errors++; $display("FAIL rst_mid_pre[%0d] got %h exp %h", i, rs[i].got, rs[i].exp); end end
    hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1; hsize[0] = 3'd2; haddr[0] = 32'h8;
    @(posedge HCLK); #1;
    hsel[0] = 1'b0; htrans[0] = 2'b00; hwdata[0] = 32'h55;
    @(negedge HCLK);
    checks++; if (hreadyout[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_wait got %b exp 0", hreadyout[0]); end
    HRESETn = 1'b0; #1;
    checks++; if ({hreadyout[0], hresp[0], hrdata[0]} !== {1'b1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL rst_mid_outputs got %b/%b/%h exp 1/0/0", hreadyout[0], hresp[0], hrdata[0]);
    end
    @(posedge HCLK); @(negedge HCLK); HRESETn = 1'b1; hwdata[0] = 32'h0;
    @(posedge HCLK); #1;
    q.push_back(mk(0, 2, 32'h8, 32'h0));
    run_seq(0);
    foreach (rs[i]) begin checks++; if (rs[i].got !== rs[i].exp) begin errors++; $display("FAIL rst_mid_post[%0d] got %h exp %h", i, rs[i].got, rs[i].exp); end end
    checks++; if (rs[rs.size()-1].got[31:0] !== 32'hCAFE0008) begin errors++; $display("FAIL rst_mid_nocommit got %h exp cafe0008", rs[rs.size()-1].got[31:0]); end
  endtask

  task automatic test_random(input int d);
    xf_t x;
    for (int k = 0; k < 16; k++) q.push_back(mk(1, 2, 32'h100 + 4*k, $urandom));
    for (int k = 0; k < 80; k++) begin
      x = mk($urandom_range(0, 1), $urandom_range(0, 3), 32'h100 + $urandom_range(0, 63), $urandom);
      if ($urandom_range(0, 9) == 0) x.trans = 2'($urandom_range(0, 1));
      else if ($urandom_range(0, 3) == 0) x.trans = 2'b11;
      if ($urandom_range(0, 9) == 0) x.sel = 1'b0;
      q.push_back(x);
    end
    run_seq(d);
    foreach (rs[i]) begin checks++; if (rs[i].got !== rs[i].exp) begin errors++; $display("FAIL random_b%0d[%0d] got %h exp %h", d, i, rs[i].got, rs[i].exp); end end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    hsel = '0; htrans = '0; hwrite = '0; hsize = '0; haddr = '0; hwdata = '0;
    test_reset();
    test_basic();
    test_byte_lanes();
    test_burst();
    test_back_to_back();
    test_error();
    test_range();
    test_reset_mid();
    test_random(0);
    test_random(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
